// File: rtl/mc_lsu.sv
// Load/store unit for the multi-cycle core: request/response handshake toward the
// core FSM, lane byte-enables, load extension, alignment checks and a fixed SRAM read latency.
module mc_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_ale,
  output logic                data_sram_en,
  output logic [DATA_W/8-1:0] data_sram_we,
  output logic [ADDR_W-1:0]   data_sram_addr,
  output logic [DATA_W-1:0]   data_sram_wdata,
  input  logic [DATA_W-1:0]   data_sram_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic             lat_we;
  logic             lat_uns;
  logic [1:0]       lat_size;
  logic [OFF_W-1:0] lat_off;
  logic [2:0]       cnt;

  logic [OFF_W-1:0]  req_off;
  logic              misaligned;
  logic [NB-1:0]     size_mask;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;
  logic [DATA_W-1:0] ld_ext;
  logic              sign_bit;
  logic [6:0]        ld_bits;

  assign req_off = req_addr[OFF_W-1:0];

  // Request decode: alignment, byte-enable mask and store data replicated into every lane.
  always_comb begin
    misaligned = 1'b0;
    size_mask  = '0;
    lane_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        size_mask  = NB'(1);
        lane_wdata = {NB{req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = req_off[0];
        size_mask  = NB'(3);
        lane_wdata = {(NB/2){req_wdata[15:0]}};
      end
      2'd2: begin
        misaligned = |req_off[1:0];
        size_mask  = NB'(15);
        lane_wdata = {(NB/4){req_wdata[31:0]}};
      end
      default: begin
        misaligned = (DATA_W == 32) || (|req_off);
        size_mask  = '1;
        lane_wdata = req_wdata;
      end
    endcase
  end

  // Load path: move the addressed lane down to bit 0, keep the access width, fill above it.
  always_comb begin
    shifted  = data_sram_rdata >> {lat_off, 3'b000};
    ld_bits  = 7'(DATA_W);
    sign_bit = shifted[DATA_W-1];
    case (lat_size)
      2'd0: begin
        ld_bits  = 7'd8;
        sign_bit = shifted[7];
      end
      2'd1: begin
        ld_bits  = 7'd16;
        sign_bit = shifted[15];
      end
      2'd2: begin
        ld_bits  = 7'd32;
        sign_bit = shifted[31];
      end
      default: begin
        ld_bits  = 7'(DATA_W);
        sign_bit = shifted[DATA_W-1];
      end
    endcase
    keep_mask = ~({DATA_W{1'b1}} << ld_bits);
    ld_ext    = (shifted & keep_mask) | ({DATA_W{sign_bit & ~lat_uns}} & ~keep_mask);
  end

  // Main FSM; SRAM strobes are set on the accepting edge so they are live throughout ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_ale        <= 1'b0;
      data_sram_en    <= 1'b0;
      data_sram_we    <= '0;
      data_sram_addr  <= '0;
      data_sram_wdata <= '0;
      lat_we          <= 1'b0;
      lat_uns         <= 1'b0;
      lat_size        <= 2'd0;
      lat_off         <= '0;
      cnt             <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_size  <= req_size;
            lat_off   <= req_off;
            req_ready <= 1'b0;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_ale   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state          <= ISSUE;
              data_sram_en   <= 1'b1;
              data_sram_we   <= req_we ? NB'(size_mask << req_off) : '0;
              data_sram_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              if (req_we) begin
                data_sram_wdata <= lane_wdata;
              end
            end
          end
        end
        ISSUE: begin
          data_sram_en <= 1'b0;
          data_sram_we <= '0;
          if (lat_we) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_ale   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= WAIT;
            cnt   <= 3'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_ale   <= 1'b0;
            resp_rdata <= ld_ext;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_ale   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_lsu.sv
// Directed bench for mc_lsu: one instance at MEM_LAT = 1 for the vector table,
// one at MEM_LAT = 4 for backpressure and reset-during-WAIT sequences.
module tb_mc_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] sram_rdata;

  logic        req_valid1, req_valid4, resp_ready1, resp_ready4;
  logic        req_ready1, resp_valid1, resp_ale1, en1;
  logic        req_ready4, resp_valid4, resp_ale4, en4;
  logic [31:0] resp_rdata1, sram_addr1, sram_wdata1;
  logic [31:0] resp_rdata4, sram_addr4, sram_wdata4;
  logic [3:0]  sram_we1, sram_we4;

  logic        sel4;
  logic        o_req_ready, o_resp_valid, o_resp_ale, o_en;
  logic [31:0] o_resp_rdata, o_addr, o_wdata;
  logic [3:0]  o_we;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_lsu #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1), .resp_ale(resp_ale1),
    .data_sram_en(en1), .data_sram_we(sram_we1), .data_sram_addr(sram_addr1),
    .data_sram_wdata(sram_wdata1), .data_sram_rdata(sram_rdata)
  );

  mc_lsu #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_rdata(resp_rdata4), .resp_ale(resp_ale4),
    .data_sram_en(en4), .data_sram_we(sram_we4), .data_sram_addr(sram_addr4),
    .data_sram_wdata(sram_wdata4), .data_sram_rdata(sram_rdata)
  );

  always_comb begin
    o_req_ready  = sel4 ? req_ready4  : req_ready1;
    o_resp_valid = sel4 ? resp_valid4 : resp_valid1;
    o_resp_ale   = sel4 ? resp_ale4   : resp_ale1;
    o_resp_rdata = sel4 ? resp_rdata4 : resp_rdata1;
    o_en         = sel4 ? en4         : en1;
    o_we         = sel4 ? sram_we4    : sram_we1;
    o_addr       = sel4 ? sram_addr4  : sram_addr1;
    o_wdata      = sel4 ? sram_wdata4 : sram_wdata1;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_ale;
    logic [3:0]  exp_be;
    logic [31:0] exp_saddr;
    logic [31:0] exp_swdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [31:0] exp_rdata, input logic exp_ale, input logic [3:0] exp_be,
                              input logic [31:0] exp_saddr, input logic [31:0] exp_swdata, input int exp_lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.exp_rdata = exp_rdata; v.exp_ale = exp_ale; v.exp_be = exp_be;
    v.exp_saddr = exp_saddr; v.exp_swdata = exp_swdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Issue one request, follow it cycle by cycle until resp_valid, then check what was seen.
  task automatic applyStimulus(input vec_t v, input bit use4, input string tag);
    int          mem_lat;
    int          lat;
    int          en_cnt;
    int          en_cyc;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    mem_lat = use4 ? 4 : 1;
    sel4 = use4;
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; sram_rdata = 32'h5A5A_5A5A;
    if (use4) req_valid4 = 1'b1; else req_valid1 = 1'b1;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    req_valid4 = 1'b0;
    lat = 0; en_cnt = 0; en_cyc = 0;
    cap_be = '0; cap_addr = '0; cap_wdata = '0;
    for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
      @(negedge clk);
      if (o_en) begin
        en_cnt++;
        en_cyc = cyc;
        cap_be = o_we; cap_addr = o_addr; cap_wdata = o_wdata;
      end
      if (o_resp_valid) lat = cyc;
      sram_rdata = (cyc == mem_lat + 1) ? v.rdata : 32'h5A5A_5A5A;
    end
    checkOutput({tag, " latency"}, lat, v.exp_lat);
    if (v.exp_ale) begin
      checkOutput({tag, " en_count"}, en_cnt, 0);
    end else begin
      checkOutput({tag, " en_count"}, en_cnt, 1);
      checkOutput({tag, " en_cycle"}, en_cyc, 1);
      checkOutput({tag, " sram_we"}, {28'd0, cap_be}, {28'd0, v.exp_be});
      checkOutput({tag, " sram_addr"}, cap_addr, v.exp_saddr);
      if (v.we) checkOutput({tag, " sram_wdata"}, cap_wdata, v.exp_swdata);
    end
    checkOutput({tag, " rdata"}, o_resp_rdata, v.exp_rdata);
    checkOutput({tag, " ale"}, {31'd0, o_resp_ale}, {31'd0, v.exp_ale});
    checkOutput({tag, " req_ready_busy"}, {31'd0, o_req_ready}, 32'd0);
  endtask

  // Consume the pending response and confirm the unit is idle on the next cycle.
  task automatic completeResp(input bit use4, input string tag);
    sel4 = use4;
    if (use4) resp_ready4 = 1'b1; else resp_ready1 = 1'b1;
    @(posedge clk);
    #1;
    resp_ready1 = 1'b0;
    resp_ready4 = 1'b0;
    @(negedge clk);
    checkOutput({tag, " idle_req_ready"}, {31'd0, o_req_ready}, 32'd1);
    checkOutput({tag, " idle_resp_valid"}, {31'd0, o_resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int hi_cnt;
    vecs[0]  = mk(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h8000_00F0, 32'h8000_00F0, 1'b0, 4'h0, 32'h1000, 32'h0, 3);
    vecs[1]  = mk(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h8512_3456, 32'hFFFF_FF85, 1'b0, 4'h0, 32'h1000, 32'h0, 3);
    vecs[2]  = mk(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h8512_3456, 32'h0000_0085, 1'b0, 4'h0, 32'h1000, 32'h0, 3);
    vecs[3]  = mk(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF, 32'h0, 32'h0, 1'b0, 4'hC, 32'h2000, 32'hBEEF_BEEF, 2);
    vecs[4]  = mk(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h1111_1111, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 1);
    vecs[5]  = mk(1'b0, 2'd3, 1'b0, 32'h3000, 32'h0, 32'h1111_1111, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 1);
    vecs[6]  = mk(1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 32'h7FFF_1234, 32'h0000_7FFF, 1'b0, 4'h0, 32'h1000, 32'h0, 3);
    vecs[7]  = mk(1'b0, 2'd1, 1'b0, 32'h1000, 32'h0, 32'h0000_9ABC, 32'hFFFF_9ABC, 1'b0, 4'h0, 32'h1000, 32'h0, 3);
    vecs[8]  = mk(1'b0, 2'd1, 1'b1, 32'h1000, 32'h0, 32'h0000_9ABC, 32'h0000_9ABC, 1'b0, 4'h0, 32'h1000, 32'h0, 3);
    vecs[9]  = mk(1'b1, 2'd0, 1'b0, 32'h4001, 32'h1234_56A5, 32'h0, 32'h0, 1'b0, 4'h2, 32'h4000, 32'hA5A5_A5A5, 2);
    vecs[10] = mk(1'b1, 2'd2, 1'b0, 32'h5004, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 4'hF, 32'h5004, 32'hDEAD_BEEF, 2);
    vecs[11] = mk(1'b0, 2'd1, 1'b0, 32'h1001, 32'h0, 32'h1111_1111, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 1);
    vecs[12] = mk(1'b0, 2'd0, 1'b0, 32'h1001, 32'h0, 32'h1234_5678, 32'h0000_0056, 1'b0, 4'h0, 32'h1000, 32'h0, 3);
    vecs[13] = mk(1'b1, 2'd1, 1'b0, 32'h2003, 32'h0000_BEEF, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 1);

    reset = 1'b1; sel4 = 1'b0;
    req_valid1 = 1'b0; req_valid4 = 1'b0; resp_ready1 = 1'b0; resp_ready4 = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; sram_rdata = '0;
    #3;
    checkOutput("reset req_ready", {31'd0, o_req_ready}, 32'd1);
    checkOutput("reset resp_valid", {31'd0, o_resp_valid}, 32'd0);
    checkOutput("reset resp_rdata", o_resp_rdata, 32'd0);
    checkOutput("reset sram_en", {31'd0, o_en}, 32'd0);
    checkOutput("reset sram_addr", o_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
      completeResp(1'b0, $sformatf("vec%0d", i));
    end

    // MEM_LAT = 4: a store first so the SRAM write-data register holds something nonzero.
    applyStimulus(mk(1'b1, 2'd0, 1'b0, 32'h6001, 32'h0000_0011, 32'h0, 32'h0, 1'b0, 4'h2, 32'h6000, 32'h1111_1111, 2),
                  1'b1, "lat4 store");
    completeResp(1'b1, "lat4 store");

    applyStimulus(mk(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4'h0, 32'h6000, 32'h0, 6),
                  1'b1, "bp load");
    sram_rdata = 32'h0;
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h3001; req_valid4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp hold%0d valid", i), {31'd0, resp_valid4}, 32'd1);
      checkOutput($sformatf("bp hold%0d rdata", i), resp_rdata4, 32'hCAFE_F00D);
      checkOutput($sformatf("bp hold%0d ale", i), {31'd0, resp_ale4}, 32'd0);
      checkOutput($sformatf("bp hold%0d req_ready", i), {31'd0, req_ready4}, 32'd0);
    end
    req_valid4 = 1'b0;
    completeResp(1'b1, "bp load");

    // Reset while the MEM_LAT = 4 instance sits in WAIT.
    sel4 = 1'b1;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h7000; sram_rdata = 32'h5A5A_5A5A;
    req_valid4 = 1'b1;
    @(posedge clk);
    #1;
    req_valid4 = 1'b0;
    @(negedge clk);
    checkOutput("rst issue en", {31'd0, en4}, 32'd1);
    @(negedge clk);
    checkOutput("rst wait req_ready", {31'd0, req_ready4}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst async req_ready", {31'd0, req_ready4}, 32'd1);
    checkOutput("rst async resp_valid", {31'd0, resp_valid4}, 32'd0);
    checkOutput("rst async resp_rdata", resp_rdata4, 32'd0);
    checkOutput("rst async ale", {31'd0, resp_ale4}, 32'd0);
    checkOutput("rst async en", {31'd0, en4}, 32'd0);
    checkOutput("rst async we", {28'd0, sram_we4}, 32'd0);
    checkOutput("rst async addr", sram_addr4, 32'd0);
    checkOutput("rst async wdata", sram_wdata4, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sram_rdata = 32'hCAFE_F00D;
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid4) hi_cnt++;
    end
    checkOutput("rst residual resp", hi_cnt, 0);
    applyStimulus(mk(1'b0, 2'd0, 1'b1, 32'h7002, 32'h0, 32'h0123_4567, 32'h0000_0023, 1'b0, 4'h0, 32'h7000, 32'h0, 6),
                  1'b1, "post-rst load");
    completeResp(1'b1, "post-rst load");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
